ssf_input_server: RTL and testbench

Input-side companion to the multi-core SSF array: buffers the upstream sample stream and answers per-core sample requests. Each core raises its `req_in` code, and the server delivers one sample to that core with a one-hot grant. The server sits between the sample source and the shared `io_in` bus of the cores. It replaces a plain broadcast of `io_in`, so every core sees each sample exactly once per request even though core reset releases are staggered.

---
 rtl/ssf_input_server_if.sv | 26 ++
 rtl/ssf_input_server.sv | 121 ++++++++++++
 tb/tb_ssf_input_server.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ssf_input_server_if.sv
// Bus bundle between the sample source, the input server and the SSF cores.
// The slave modport is the server side; master is the source/core side.
interface ssf_input_server_if #(
  parameter int unsigned NCORES = 33,
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0]   s_data;
  logic                s_valid;
  logic                s_ready;
  logic [2*NCORES-1:0] req_in;
  logic [DATA_W-1:0]   io_in;
  logic                io_valid;
  logic [NCORES-1:0]   grant;
  logic [15:0]         served_cnt;
  logic                starved;

  modport master (
    output s_data, s_valid, req_in,
    input  s_ready, io_in, io_valid, grant, served_cnt, starved
  );

  modport slave (
    input  s_data, s_valid, req_in,
    output s_ready, io_in, io_valid, grant, served_cnt, starved
  );
endinterface

// File: rtl/ssf_input_server.sv
// Sample FIFO plus round-robin request server: delivers one buffered sample
// per rising request edge to the requesting SSF core with a one-hot grant.
module ssf_input_server #(
  parameter int unsigned NCORES = 33,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input logic               clk,
  input logic               rst_n,
  ssf_input_server_if.slave bus
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned CW   = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CW-1:0]   LAST_RST = CW'(NCORES - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNTW-1:0]   count;
  logic              full;
  logic              push;
  logic              pop;

  logic [NCORES-1:0] req_now;
  logic [NCORES-1:0] prev_req;
  logic [NCORES-1:0] rise;
  logic [NCORES-1:0] pending;
  logic [NCORES-1:0] cand;
  logic [NCORES-1:0] win_oh;
  logic [CW-1:0]     last;
  logic [CW-1:0]     win;
  logic              found;
  logic              grant_now;

  assign full        = (count == FULL_CNT);
  assign bus.s_ready = rst_n & ~full;
  assign push        = bus.s_valid & bus.s_ready;
  assign pop         = grant_now;

  always_comb begin
    req_now = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      req_now[i] = (bus.req_in[2*i +: 2] == 2'd1);
    end
  end

  assign rise = req_now & ~prev_req;
  assign cand = pending | rise;

  // Round-robin search starting just above the last winner, wrapping at NCORES.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NCORES; k++) begin
      idx = int'(last) + k;
      if (idx >= NCORES) idx = idx - NCORES;
      if (!found && cand[CW'(idx)]) begin
        found = 1'b1;
        win   = CW'(idx);
      end
    end
  end

  // Only the occupancy before this edge counts, so a same-cycle push is never served.
  assign grant_now = found && (count != '0);

  always_comb begin
    win_oh = '0;
    if (grant_now) win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      prev_req       <= '0;
      pending        <= '0;
      last           <= LAST_RST;
      bus.io_in      <= '0;
      bus.io_valid   <= 1'b0;
      bus.grant      <= '0;
      bus.served_cnt <= '0;
      bus.starved    <= 1'b0;
    end else begin
      prev_req <= req_now;
      pending  <= cand & ~win_oh;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (grant_now) begin
        bus.io_in      <= mem[rd_ptr];
        bus.io_valid   <= 1'b1;
        bus.grant      <= win_oh;
        bus.served_cnt <= bus.served_cnt + 16'd1;
        last           <= win;
      end else begin
        bus.io_valid <= 1'b0;
        bus.grant    <= '0;
      end

      if ((cand != '0) && (count == '0)) bus.starved <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssf_input_server.sv
// Directed bench for ssf_input_server: vector table for delivery/arbitration,
// plus hand sequences for backpressure, level hold and async reset.
module tb_ssf_input_server;

  localparam int unsigned NC = 33;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ssf_input_server_if #(.NCORES(NC), .DATA_W(32)) bus ();

  ssf_input_server #(.NCORES(NC), .DATA_W(32), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          pre_rst;
    bit          sv;
    logic [31:0] sd;
    logic [32:0] m1;       // cores driving code 1
    logic [32:0] m3;       // cores driving code 3 (not a request)
    bit          e_valid;
    logic [32:0] e_grant;
    logic [31:0] e_io;
    logic [15:0] e_served;
    bit          e_starved;
    bit          e_ready;
  } vec_t;

  vec_t vt[$];

  function automatic logic [32:0] b(input int n);
    logic [32:0] one;
    one = 33'd1;
    return one << n;
  endfunction

  function automatic logic [65:0] codes(input logic [32:0] m1, input logic [32:0] m3);
    logic [65:0] c;
    c = '0;
    for (int i = 0; i < NC; i++) begin
      if (m1[i])      c[2*i +: 2] = 2'd1;
      else if (m3[i]) c[2*i +: 2] = 2'd3;
    end
    return c;
  endfunction

  function automatic vec_t mk(input bit pr, input bit sv, input logic [31:0] sd,
                              input logic [32:0] m1, input logic [32:0] m3,
                              input bit ev, input logic [32:0] eg, input logic [31:0] eio,
                              input logic [15:0] es, input bit est, input bit erd);
    vec_t v;
    v.pre_rst = pr; v.sv = sv; v.sd = sd; v.m1 = m1; v.m3 = m3;
    v.e_valid = ev; v.e_grant = eg; v.e_io = eio; v.e_served = es;
    v.e_starved = est; v.e_ready = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sv, input logic [31:0] sd, input logic [32:0] m1, input logic [32:0] m3);
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.req_in  = codes(m1, m3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit sv, input logic [31:0] sd, input logic [32:0] m1);
    @(negedge clk);
    drive(sv, sd, m1, '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0);

    // Async reset values before any clock edge
    #2;
    chk("rst.io_valid", 64'(bus.io_valid), 64'd0);
    chk("rst.grant", 64'(bus.grant), 64'd0);
    chk("rst.io_in", 64'(bus.io_in), 64'd0);
    chk("rst.served", 64'(bus.served_cnt), 64'd0);
    chk("rst.starved", 64'(bus.starved), 64'd0);
    chk("rst.s_ready", 64'(bus.s_ready), 64'd0);

    //        pr sv sd            m1               m3    ev eg     eio           es   st rd
    vt.push_back(mk(1, 1, 32'h5,        '0,              '0,   0, '0,    32'h0,        0,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(0),            '0,   1, b(0),  32'h5,        1,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(0),            '0,   0, '0,    32'h5,        1,  0, 1));
    vt.push_back(mk(1, 1, 32'hFFFFFFFF, '0,              '0,   0, '0,    32'h0,        0,  0, 1));
    vt.push_back(mk(0, 1, 32'h2,        '0,              '0,   0, '0,    32'h0,        0,  0, 1));
    vt.push_back(mk(0, 1, 32'h3,        '0,              '0,   0, '0,    32'h0,        0,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(0)|b(5)|b(32), '0,   1, b(0),  32'hFFFFFFFF, 1,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(0)|b(5)|b(32), '0,   1, b(5),  32'h2,        2,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(0)|b(5)|b(32), '0,   1, b(32), 32'h3,        3,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        '0,              '0,   0, '0,    32'h3,        3,  0, 1));
    vt.push_back(mk(0, 1, 32'd10,       '0,              '0,   0, '0,    32'h3,        3,  0, 1));
    vt.push_back(mk(0, 1, 32'd11,       b(5),            '0,   1, b(5),  32'd10,       4,  0, 1));
    vt.push_back(mk(0, 1, 32'd12,       '0,              '0,   0, '0,    32'd10,       4,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(0)|b(5),       '0,   1, b(0),  32'd11,       5,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(0)|b(5),       '0,   1, b(5),  32'd12,       6,  0, 1));
    vt.push_back(mk(0, 1, 32'd20,       '0,              '0,   0, '0,    32'd12,       6,  0, 1));
    vt.push_back(mk(0, 1, 32'd21,       b(0),            '0,   1, b(0),  32'd20,       7,  0, 1));
    vt.push_back(mk(0, 1, 32'd22,       '0,              '0,   0, '0,    32'd20,       7,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(0)|b(5),       '0,   1, b(5),  32'd21,       8,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(0)|b(5),       '0,   1, b(0),  32'd22,       9,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        '0,              '0,   0, '0,    32'd22,       9,  0, 1));
    vt.push_back(mk(0, 1, 32'd30,       '0,              b(3), 0, '0,    32'd22,       9,  0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(3),            '0,   1, b(3),  32'd30,       10, 0, 1));
    vt.push_back(mk(0, 0, 32'h0,        '0,              '0,   0, '0,    32'd30,       10, 0, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(7),            '0,   0, '0,    32'd30,       10, 1, 1));
    vt.push_back(mk(0, 1, 32'd40,       b(7),            '0,   0, '0,    32'd30,       10, 1, 1));
    vt.push_back(mk(0, 0, 32'h0,        b(7),            '0,   1, b(7),  32'd40,       11, 1, 1));

    foreach (vt[i]) begin
      if (vt[i].pre_rst) do_reset();
      else @(negedge clk);
      drive(vt[i].sv, vt[i].sd, vt[i].m1, vt[i].m3);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.io_valid", i), 64'(bus.io_valid), 64'(vt[i].e_valid));
      chk($sformatf("v%0d.grant", i), 64'(bus.grant), 64'(vt[i].e_grant));
      chk($sformatf("v%0d.io_in", i), 64'(bus.io_in), 64'(vt[i].e_io));
      chk($sformatf("v%0d.served", i), 64'(bus.served_cnt), 64'(vt[i].e_served));
      chk($sformatf("v%0d.starved", i), 64'(bus.starved), 64'(vt[i].e_starved));
      chk($sformatf("v%0d.s_ready", i), 64'(bus.s_ready), 64'(vt[i].e_ready));
    end

    // Full / backpressure
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 32'(100 + i), '0);
    chk("full.s_ready", 64'(bus.s_ready), 64'd0);
    step(1'b1, 32'hDEAD, '0);
    chk("full.s_ready_hold", 64'(bus.s_ready), 64'd0);
    chk("full.no_valid", 64'(bus.io_valid), 64'd0);
    step(1'b0, '0, b(1));
    chk("full.first_valid", 64'(bus.io_valid), 64'd1);
    chk("full.first_io", 64'(bus.io_in), 64'd100);
    chk("full.first_grant", 64'(bus.grant), 64'(b(1)));
    chk("full.ready_after_pop", 64'(bus.s_ready), 64'd1);
    for (int j = 1; j < 16; j++) begin
      step(1'b0, '0, '0);
      step(1'b0, '0, b(1));
      chk($sformatf("drain%0d.io_valid", j), 64'(bus.io_valid), 64'd1);
      chk($sformatf("drain%0d.io_in", j), 64'(bus.io_in), 64'(100 + j));
    end
    step(1'b0, '0, '0);
    step(1'b0, '0, b(1));
    chk("drain.extra_no_valid", 64'(bus.io_valid), 64'd0);
    chk("drain.starved", 64'(bus.starved), 64'd1);
    chk("drain.served", 64'(bus.served_cnt), 64'd16);

    // Level hold for 10 cycles yields one delivery
    do_reset();
    step(1'b1, 32'd7, '0);
    step(1'b1, 32'd8, '0);
    step(1'b1, 32'd9, '0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, b(2));
      if (bus.io_valid) pulses++;
    end
    chk("hold.pulses", 64'(pulses), 64'd1);
    chk("hold.served", 64'(bus.served_cnt), 64'd1);
    step(1'b0, '0, '0);
    step(1'b0, '0, b(2));
    chk("hold.rereq_io", 64'(bus.io_in), 64'd8);
    chk("hold.rereq_grant", 64'(bus.grant), 64'(b(2)));

    // Asynchronous reset mid-stream
    do_reset();
    step(1'b0, '0, b(9));
    step(1'b1, 32'hA0, b(9));
    step(1'b1, 32'hB0, b(9));
    chk("ar.grant9_io", 64'(bus.io_in), 64'hA0);
    step(1'b1, 32'hC0, '0);
    step(1'b1, 32'hD0, b(3) | b(4));
    chk("ar.pre_valid", 64'(bus.io_valid), 64'd1);
    chk("ar.pre_grant", 64'(bus.grant), 64'(b(3)));
    chk("ar.pre_io", 64'(bus.io_in), 64'hB0);
    chk("ar.pre_served", 64'(bus.served_cnt), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar.io_valid", 64'(bus.io_valid), 64'd0);
    chk("ar.grant", 64'(bus.grant), 64'd0);
    chk("ar.io_in", 64'(bus.io_in), 64'd0);
    chk("ar.served", 64'(bus.served_cnt), 64'd0);
    chk("ar.starved", 64'(bus.starved), 64'd0);
    chk("ar.s_ready", 64'(bus.s_ready), 64'd0);
    drive(1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, '0);
      if (bus.io_valid) pulses++;
    end
    chk("ar.idle_pulses", 64'(pulses), 64'd0);
    step(1'b0, '0, b(4));
    chk("ar.req_no_valid", 64'(bus.io_valid), 64'd0);
    chk("ar.req_starved", 64'(bus.starved), 64'd1);
    step(1'b1, 32'hE0, b(4));
    chk("ar.push_no_valid", 64'(bus.io_valid), 64'd0);
    step(1'b0, '0, b(4));
    chk("ar.deliver_valid", 64'(bus.io_valid), 64'd1);
    chk("ar.deliver_io", 64'(bus.io_in), 64'hE0);
    chk("ar.deliver_grant", 64'(bus.grant), 64'(b(4)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
